// File: rtl/spi_cmd_regfile.sv
// Command decoder and byte-wide register file behind an SPI slave: decodes R/W + address
// command bytes, performs auto-incrementing writes/reads and supplies the next MISO byte.
module spi_cmd_regfile #(
    parameter int          NREGS    = 8,
    parameter logic [7:0]  ID_VALUE = 8'hA5,
    parameter logic [7:0]  RD_FILL  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_active,
    input  logic                 frame_start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [7:0]           tx_data,
    output logic                 wr_strobe,
    output logic [6:0]           wr_addr,
    output logic [NREGS*8-1:0]   reg_out,
    output logic [7:0]           err_count
);

    localparam int         IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [6:0] NREGS_A  = 7'(NREGS);
    localparam logic [6:0] ERR_ADDR = 7'h7E;
    localparam logic [6:0] ID_ADDR  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [6:0]  addr_r;
    logic [6:0]  addr_nx_s;
    logic [7:0]  tx_data_r;
    logic [7:0]  tx_nx_s;
    logic        load_pend_r;
    logic        load_pend_nx_s;
    logic        wr_strobe_r;
    logic        wr_strobe_nx_s;
    logic [6:0]  wr_addr_r;
    logic [6:0]  wr_addr_nx_s;
    logic [7:0]  err_count_r;
    logic        err_inc_s;
    logic        reg_we_s;
    logic [7:0]  rd_data_s;
    logic        rd_unmapped_s;
    logic [7:0]  regs_r [NREGS];

    function automatic logic is_reg_addr(input logic [6:0] a);
        return (a < NREGS_A);
    endfunction

    // Read mux for the address held in addr_r; flags unmapped reads
    always_comb begin
        rd_data_s     = RD_FILL;
        rd_unmapped_s = 1'b0;
        if (is_reg_addr(addr_r)) begin
            rd_data_s = regs_r[addr_r[IW-1:0]];
        end else if (addr_r == ERR_ADDR) begin
            rd_data_s = err_count_r;
        end else if (addr_r == ID_ADDR) begin
            rd_data_s = ID_VALUE;
        end else begin
            rd_data_s     = RD_FILL;
            rd_unmapped_s = 1'b1;
        end
    end

    // Next-state and datapath control; frame end beats frame start beats byte handling
    always_comb begin
        state_nx_s     = state_r;
        addr_nx_s      = addr_r;
        tx_nx_s        = tx_data_r;
        load_pend_nx_s = 1'b0;
        wr_strobe_nx_s = 1'b0;
        wr_addr_nx_s   = wr_addr_r;
        err_inc_s      = 1'b0;
        reg_we_s       = 1'b0;
        if (!frame_active) begin
            state_nx_s = IDLE;
            tx_nx_s    = 8'h00;
        end else if (frame_start) begin
            state_nx_s = CMD;
            tx_nx_s    = ID_VALUE;
        end else begin
            // A read prefetch requested on the previous rx_valid lands here
            if (load_pend_r) begin
                tx_nx_s   = rd_data_s;
                err_inc_s = rd_unmapped_s;
            end else begin
                tx_nx_s = tx_data_r;
            end
            case (state_r)
                IDLE: begin
                    state_nx_s = IDLE;
                end
                CMD: begin
                    if (rx_valid) begin
                        addr_nx_s = rx_data[6:0];
                        if (rx_data[7]) begin
                            state_nx_s = WRITE;
                            tx_nx_s    = 8'h00;
                        end else begin
                            state_nx_s     = READ;
                            load_pend_nx_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = CMD;
                    end
                end
                WRITE: begin
                    if (rx_valid) begin
                        addr_nx_s = addr_r + 7'd1;
                        if (is_reg_addr(addr_r)) begin
                            reg_we_s       = 1'b1;
                            wr_strobe_nx_s = 1'b1;
                            wr_addr_nx_s   = addr_r;
                        end else begin
                            err_inc_s = 1'b1;
                        end
                    end else begin
                        addr_nx_s = addr_r;
                    end
                end
                READ: begin
                    if (rx_valid) begin
                        addr_nx_s      = addr_r + 7'd1;
                        load_pend_nx_s = 1'b1;
                    end else begin
                        addr_nx_s = addr_r;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Address, MISO byte, write strobe and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r      <= 7'd0;
            tx_data_r   <= 8'h00;
            load_pend_r <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 7'd0;
            err_count_r <= 8'h00;
        end else begin
            addr_r      <= addr_nx_s;
            tx_data_r   <= tx_nx_s;
            load_pend_r <= load_pend_nx_s;
            wr_strobe_r <= wr_strobe_nx_s;
            wr_addr_r   <= wr_addr_nx_s;
            if (err_inc_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    // Register file storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (reg_we_s) begin
            regs_r[addr_r[IW-1:0]] <= rx_data;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg_out
        assign reg_out[8*g +: 8] = regs_r[g];
    end

    assign tx_data   = tx_data_r;
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Bench for spi_cmd_regfile: directed frames plus random frames, checked against a
// byte-level model of the register map kept in plain arrays.
module tb_spi_cmd_regfile;

    localparam int         NREGS = 8;
    localparam logic [7:0] ID    = 8'hA5;
    localparam logic [7:0] FILL  = 8'h00;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 frame_active;
    logic                 frame_start;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic [7:0]           tx_data;
    logic                 wr_strobe;
    logic [6:0]           wr_addr;
    logic [NREGS*8-1:0]   reg_out;
    logic [7:0]           err_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_regs [NREGS];
    logic [7:0] m_err;
    logic [7:0] data_a [300];

    spi_cmd_regfile #(.NREGS(NREGS), .ID_VALUE(ID), .RD_FILL(FILL)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .frame_start  (frame_start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_data      (tx_data),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .reg_out      (reg_out),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_err = 8'h00;
    endtask

    task automatic m_bump();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // Value the map returns for address a; unmapped reads count as errors
    function automatic logic [7:0] m_read(input logic [6:0] a);
        logic [7:0] v;
        if (int'(a) < NREGS)      v = m_regs[a[2:0]];
        else if (a == 7'h7E)      v = m_err;
        else if (a == 7'h7F)      v = ID;
        else begin
            v = FILL;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        return v;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_err"}, {24'd0, err_count}, {24'd0, m_err});
        for (int i = 0; i < NREGS; i++) begin
            check($sformatf("%s_reg%0d", tag, i), {24'd0, reg_out[8*i +: 8]}, {24'd0, m_regs[i]});
        end
    endtask

    task automatic start_frame();
        frame_active = 1'b1;
        frame_start  = 1'b1;
        tick();
        frame_start = 1'b0;
        check("tx_id", {24'd0, tx_data}, {24'd0, ID});
    endtask

    task automatic end_frame(input string tag);
        frame_active = 1'b0;
        tick();
        check({tag, "_tx_idle"}, {24'd0, tx_data}, 32'd0);
        check_state(tag);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input int ndata);
        logic [6:0] a;
        logic       wr;
        a  = cmd[6:0];
        wr = cmd[7];
        start_frame();
        rx_data  = cmd;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("cmd_strobe", {31'd0, wr_strobe}, 32'd0);
        tick();
        check("cmd_tx", {24'd0, tx_data}, {24'd0, (wr ? 8'h00 : m_read(a))});
        for (int i = 0; i < ndata; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            rx_data  = data_a[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            if (wr) begin
                if (int'(a) < NREGS) begin
                    check("wr_strobe", {31'd0, wr_strobe}, 32'd1);
                    check("wr_addr", {25'd0, wr_addr}, {25'd0, a});
                    m_regs[a[2:0]] = data_a[i];
                end else begin
                    check("wr_drop", {31'd0, wr_strobe}, 32'd0);
                    m_bump();
                end
            end
            a = a + 7'd1;
            tick();
            check("wr_pulse_end", {31'd0, wr_strobe}, 32'd0);
            check("data_tx", {24'd0, tx_data}, {24'd0, (wr ? 8'h00 : m_read(a))});
        end
        end_frame(tag);
    endtask

    initial begin
        logic [7:0] cmd;
        rst          = 1'b1;
        frame_active = 1'b0;
        frame_start  = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        model_reset();
        repeat (2) tick();
        check("rst_tx", {24'd0, tx_data}, 32'd0);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
        check_state("rst");
        rst = 1'b0;
        tick();

        // Two-byte write starting at address 1
        data_a[0] = 8'hCC; data_a[1] = 8'hDD;
        run_frame("t1", 8'h81, 2);
        check("t1_reg1", {24'd0, reg_out[15:8]}, 32'hCC);
        check("t1_reg2", {24'd0, reg_out[23:16]}, 32'hDD);

        // Read back from address 1
        data_a[0] = 8'h5A; data_a[1] = 8'h3C;
        run_frame("t2", 8'h01, 2);

        // Writes running off the end of the register range
        data_a[0] = 8'h11; data_a[1] = 8'h22;
        run_frame("t3a", 8'h87, 2);
        run_frame("t3b", 8'h86, 2);

        // Read across the 7E/7F/00 wrap
        run_frame("t4", 8'h7E, 2);

        // Frame end on the same cycle as a data byte
        start_frame();
        rx_data = 8'h80; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        rx_data = 8'h55; rx_valid = 1'b1; frame_active = 1'b0;
        tick();
        rx_valid = 1'b0;
        check("t5_strobe", {31'd0, wr_strobe}, 32'd0);
        check("t5_tx", {24'd0, tx_data}, 32'd0);
        frame_active = 1'b1;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("t5_idle_strobe", {31'd0, wr_strobe}, 32'd0);
        tick();
        check("t5_idle_tx", {24'd0, tx_data}, 32'd0);
        end_frame("t5");

        // Reset in the middle of a write frame
        start_frame();
        rx_data = 8'h82; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        rx_data = 8'h33; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("t6_tx", {24'd0, tx_data}, 32'd0);
        check_state("t6");
        frame_active = 1'b0;
        tick();
        data_a[0] = 8'h44;
        run_frame("t6b", 8'h80, 1);

        // Random frames biased towards the map boundaries
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 3))
                0:       cmd = 8'($urandom_range(0, 9));
                1:       cmd = 8'($urandom_range(8'h7C, 8'h7F));
                2:       cmd = 8'($urandom_range(0, 8'h7F));
                default: cmd = 8'($urandom_range(0, 7));
            endcase
            cmd[7] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 6; i++) data_a[i] = 8'($urandom);
            run_frame("rnd", cmd, $urandom_range(0, 5));
        end

        // Long write frame drives the error counter into saturation
        for (int i = 0; i < 300; i++) data_a[i] = 8'($urandom);
        run_frame("sat", 8'hA0, 300);
        check("sat_err", {24'd0, err_count}, 32'hFF);
        data_a[0] = 8'h00; data_a[1] = 8'h00;
        run_frame("sat_rd", 8'h40, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
